// File: rtl/mux_4_pkg.sv
// Shared definitions for the registered 4:1 selector: select-field type,
// select-code constants and the legal data-width range.
package mux_4_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/mux_4_if.sv
// Bus bundle for mux_4: four data inputs, select, capture strobe and the
// registered result with its valid flag.
interface mux_4_if
  import mux_4_pkg::*;
#(
  parameter int WIDTH = 1
);

  // Handshake: in_valid is a pure capture strobe with no ready/backpressure;
  // every edge with in_valid=1 is accepted, and out_valid is high exactly for
  // the cycle after such an edge, while outp holds that fresh selection.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             s;
  logic             in_valid;
  logic [WIDTH-1:0] outp;
  logic             out_valid;

  modport master (
    output a, b, c, d, s, in_valid,
    input  outp, out_valid
  );

  modport slave (
    input  a, b, c, d, s, in_valid,
    output outp, out_valid
  );

endinterface

// File: rtl/mux_4_sel.sv
// Purely combinational WIDTH-bit 4:1 selector keyed on the package select codes.
module mux_4_sel
  import mux_4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             s,
  output logic [WIDTH-1:0] y
);

  // All four codes are legal, so the case is full without a default arm.
  always_comb begin
    y = a;
    case (s)
      SEL_A: y = a;
      SEL_B: y = b;
      SEL_C: y = c;
      SEL_D: y = d;
    endcase
  end

endmodule

// File: rtl/mux_4.sv
// Registered 4:1 selector: one-cycle latency, capture qualified by in_valid,
// asynchronous active-low reset clearing both outp and out_valid.
module mux_4
  import mux_4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_4_if.slave    bus
);

  logic [WIDTH-1:0] sel_y;
  logic [WIDTH-1:0] outp_q;
  logic             valid_q;

  mux_4_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .a (bus.a),
    .b (bus.b),
    .c (bus.c),
    .d (bus.d),
    .s (bus.s),
    .y (sel_y)
  );

  // outp only moves on a capturing edge; idle edges just drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        outp_q <= sel_y;
      end
    end
  end

  assign bus.outp      = outp_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_4.sv
// Bench for mux_4: WIDTH=8 and WIDTH=1 instances driven in lockstep, with a
// queue-based scoreboard fed by the driver and drained by a negedge monitor.
module tb_mux_4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_4_if #(.WIDTH(8)) bus8 ();
  mux_4_if #(.WIDTH(1)) bus1 ();

  mux_4 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  mux_4 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic [7:0] exp8_q[$];
  logic [0:0] exp1_q[$];
  logic       vld_q[$];

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] last8 = 8'h00;
  logic [0:0] last1 = 1'b0;
  logic [7:0] prev8 = 8'h00;
  logic [0:0] prev1 = 1'b0;
  logic       mv;
  logic [7:0] e8;
  logic [0:0] e1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [7:0] a8, input logic [7:0] b8, input logic [7:0] c8,
                       input logic [7:0] d8, input logic [3:0] w1, input logic [1:0] s,
                       input logic v);
    bus8.a = a8; bus8.b = b8; bus8.c = c8; bus8.d = d8;
    bus1.a = w1[0]; bus1.b = w1[1]; bus1.c = w1[2]; bus1.d = w1[3];
    bus8.s = s; bus1.s = s;
    bus8.in_valid = v; bus1.in_valid = v;
  endtask

  // Reference model: the selected operand is simply the s-th element of {a,b,c,d}.
  task automatic push(input logic [7:0] a8, input logic [7:0] b8, input logic [7:0] c8,
                      input logic [7:0] d8, input logic [3:0] w1, input logic [1:0] s,
                      input logic v);
    logic [7:0] vals8[4];
    vals8 = '{a8, b8, c8, d8};
    vld_q.push_back(v);
    if (v) begin
      exp8_q.push_back(vals8[s]);
      exp1_q.push_back(w1[s]);
      prev8 = vals8[s];
      prev1 = w1[s];
    end
  endtask

  task automatic drive(input logic [7:0] a8, input logic [7:0] b8, input logic [7:0] c8,
                       input logic [7:0] d8, input logic [3:0] w1, input logic [1:0] s,
                       input logic v);
    @(posedge clk);
    #2;
    apply(a8, b8, c8, d8, w1, s, v);
    push(a8, b8, c8, d8, w1, s, v);
  endtask

  task automatic drive_rand(input logic v);
    drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), v);
  endtask

  // Inputs change twice inside one cycle; outp must not follow either change.
  task automatic drive_iso();
    logic [7:0] a8, b8, c8, d8;
    logic [3:0] w1;
    logic [1:0] s;
    @(posedge clk);
    #2;
    apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'b1);
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    c8 = 8'($urandom_range(0, 255)); d8 = 8'($urandom_range(0, 255));
    w1 = 4'($urandom_range(0, 15));  s  = 2'($urandom_range(0, 3));
    #1;
    apply(a8, b8, c8, d8, w1, s, 1'b1);
    #1;
    check("iso_outp8", 64'(bus8.outp), 64'(prev8));
    check("iso_outp1", 64'(bus1.outp), 64'(prev1));
    push(a8, b8, c8, d8, w1, s, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en && vld_q.size() > 0) begin
      mv = vld_q.pop_front();
      check("out_valid8", 64'(bus8.out_valid), 64'(mv));
      check("out_valid1", 64'(bus1.out_valid), 64'(mv));
      if (bus8.out_valid) begin
        if (exp8_q.size() == 0) begin
          check("unexpected_out8", 64'(1), 64'(0));
        end else begin
          e8 = exp8_q.pop_front();
          check("outp8", 64'(bus8.outp), 64'(e8));
          last8 = e8;
        end
      end else begin
        check("hold8", 64'(bus8.outp), 64'(last8));
      end
      if (bus1.out_valid) begin
        if (exp1_q.size() == 0) begin
          check("unexpected_out1", 64'(1), 64'(0));
        end else begin
          e1 = exp1_q.pop_front();
          check("outp1", 64'(bus1.outp), 64'(e1));
          last1 = e1;
        end
      end else begin
        check("hold1", 64'(bus1.outp), 64'(last1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a live capture request: nothing may be captured.
    rst_n = 1'b0;
    apply(8'h11, 8'h22, 8'h33, 8'h44, 4'b0010, 2'd1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("rst_outp8", 64'(bus8.outp), 64'(0));
      check("rst_valid8", 64'(bus8.out_valid), 64'(0));
      check("rst_outp1", 64'(bus1.outp), 64'(0));
      check("rst_valid1", 64'(bus1.out_valid), 64'(0));
    end
    #1;
    rst_n = 1'b1;
    push(8'h11, 8'h22, 8'h33, 8'h44, 4'b0010, 2'd1, 1'b1);
    mon_en = 1'b1;

    // Select sweep: WIDTH=1 data a=0 b=1 c=0 d=1.
    for (int i = 0; i < 4; i++) begin
      drive(8'h11, 8'h22, 8'h33, 8'h44, 4'b1010, 2'(i), 1'b1);
    end
    drive(8'h11, 8'h22, 8'h33, 8'h44, 4'b1010, 2'd3, 1'b1);
    drive(8'h11, 8'h22, 8'h33, 8'h44, 4'b1010, 2'd0, 1'b1);

    // Hold: capture 8'hA5 then idle while inputs churn.
    drive(8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100, 2'd2, 1'b1);
    repeat (3) drive_rand(1'b0);

    drive_rand(1'b1);
    repeat (4) drive_iso();

    // Mid-stream asynchronous reset between edges.
    repeat (3) drive_rand(1'b1);
    drive_rand(1'b1);
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outp8", 64'(bus8.outp), 64'(0));
    check("mid_rst_valid8", 64'(bus8.out_valid), 64'(0));
    check("mid_rst_outp1", 64'(bus1.outp), 64'(0));
    check("mid_rst_valid1", 64'(bus1.out_valid), 64'(0));
    last8 = 8'h00;
    last1 = 1'b0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      drive_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    repeat (2) drive_rand(1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("drain_vld_q", 64'(vld_q.size()), 64'(0));
    check("drain_exp8_q", 64'(exp8_q.size()), 64'(0));
    check("drain_exp1_q", 64'(exp1_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
